// File: rtl/frame_bank_scheduler_if.sv
// Handshake bundle between the frame writer/reader control and the triple-buffer
// bank scheduler. CNT_W must match the scheduler's CNT_W.
interface frame_bank_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             sdram_init_done;
  logic             wr_frame_done;
  logic             rd_frame_start;
  logic [1:0]       wr_bank;
  logic [1:0]       rd_bank;
  logic             wr_load;
  logic             rd_load;
  logic             disp_valid;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;

  modport master (
    output sdram_init_done, wr_frame_done, rd_frame_start,
    input  wr_bank, rd_bank, wr_load, rd_load, disp_valid, drop_cnt, repeat_cnt
  );

  modport slave (
    input  sdram_init_done, wr_frame_done, rd_frame_start,
    output wr_bank, rd_bank, wr_load, rd_load, disp_valid, drop_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Triple/quad-buffer SDRAM bank scheduler: the reader only switches to fully written
// frames, so the display never tears. Dropped and repeated frames are counted.
module frame_bank_scheduler #(
  parameter int NUM_BANKS = 3,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  frame_bank_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] RD_BANK_RESET = 2'(NUM_BANKS - 1);

  state_t           state_q;
  logic [1:0]       wr_bank_q;
  logic [1:0]       rd_bank_q;
  logic [1:0]       latest_q;
  logic             latest_valid_q;
  logic             wr_load_q;
  logic             rd_load_q;
  logic             disp_valid_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] repeat_q;

  // Lowest bank index that is neither a nor b; with NUM_BANKS >= 3 one always exists.
  function automatic logic [1:0] lowest_free(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!found && (2'(i) != a) && (2'(i) != b)) begin
        pick  = 2'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_bank_q      <= '0;
      rd_bank_q      <= RD_BANK_RESET;
      latest_q       <= '0;
      latest_valid_q <= 1'b0;
      wr_load_q      <= 1'b0;
      rd_load_q      <= 1'b0;
      disp_valid_q   <= 1'b0;
      drop_q         <= '0;
      repeat_q       <= '0;
    end else begin
      wr_load_q <= 1'b0;
      rd_load_q <= 1'b0;
      // Losing the SDRAM drops back to the reset picture, but the statistics survive.
      if (!bus.sdram_init_done) begin
        state_q        <= IDLE;
        wr_bank_q      <= '0;
        rd_bank_q      <= RD_BANK_RESET;
        latest_q       <= '0;
        latest_valid_q <= 1'b0;
        disp_valid_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= INIT;
            wr_load_q <= 1'b1;
            rd_load_q <= 1'b1;
          end
          INIT: state_q <= RUN;
          RUN: begin
            if (bus.wr_frame_done && bus.rd_frame_start) begin
              // Reader grabs the frame that just finished; any older pending frame is lost.
              if (latest_valid_q && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
              latest_valid_q <= 1'b0;
              rd_bank_q      <= wr_bank_q;
              wr_bank_q      <= lowest_free(wr_bank_q, wr_bank_q);
              disp_valid_q   <= 1'b1;
              wr_load_q      <= 1'b1;
              rd_load_q      <= 1'b1;
            end else if (bus.wr_frame_done) begin
              if (latest_valid_q && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
              latest_q       <= wr_bank_q;
              latest_valid_q <= 1'b1;
              wr_bank_q      <= lowest_free(rd_bank_q, wr_bank_q);
              wr_load_q      <= 1'b1;
            end else if (bus.rd_frame_start) begin
              if (latest_valid_q) begin
                rd_bank_q      <= latest_q;
                latest_valid_q <= 1'b0;
                disp_valid_q   <= 1'b1;
              end else if (repeat_q != '1) begin
                repeat_q <= repeat_q + CNT_W'(1);
              end
              rd_load_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.wr_bank    = wr_bank_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.wr_load    = wr_load_q;
  assign bus.rd_load    = rd_load_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.repeat_cnt = repeat_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: directed vector table, saturation sequence
// on a narrow-counter instance, then random traffic against a behavioural model.
module tb_frame_bank_scheduler;

  localparam int NUM_BANKS = 3;
  localparam int SMALL_MAX = 3;
  localparam int BIG_MAX   = 65535;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  logic wr_done;
  logic rd_start;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  frame_bank_scheduler_if #(.CNT_W(16)) big_if ();
  frame_bank_scheduler_if #(.CNT_W(2))  small_if ();

  assign big_if.sdram_init_done   = init_done;
  assign big_if.wr_frame_done     = wr_done;
  assign big_if.rd_frame_start    = rd_start;
  assign small_if.sdram_init_done = init_done;
  assign small_if.wr_frame_done   = wr_done;
  assign small_if.rd_frame_start  = rd_start;

  frame_bank_scheduler #(.NUM_BANKS(NUM_BANKS), .CNT_W(16)) dut_big (
    .clk(clk), .rst_n(rst_n), .bus(big_if.slave)
  );

  frame_bank_scheduler #(.NUM_BANKS(NUM_BANKS), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(small_if.slave)
  );

  // Behavioural model: banks as plain ints, "up time" instead of a state machine.
  int m_wr, m_rd, m_latest, m_latest_valid, m_disp, m_wl, m_rl, m_drop, m_rep, up_cycles;

  function automatic int free_bank(int a, int b);
    for (int i = 0; i < NUM_BANKS; i++)
      if (i != a && i != b) return i;
    return 0;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    m_wr = 0; m_rd = NUM_BANKS - 1; m_latest = 0; m_latest_valid = 0;
    m_disp = 0; m_wl = 0; m_rl = 0; m_drop = 0; m_rep = 0; up_cycles = 0;
  endtask

  task automatic modelStep(bit init, bit wf, bit rs);
    bit running;
    int old_wr;
    running = (up_cycles >= 2);
    m_wl = 0;
    m_rl = 0;
    if (!init) begin
      up_cycles = 0; m_wr = 0; m_rd = NUM_BANKS - 1; m_latest_valid = 0; m_disp = 0;
      return;
    end
    up_cycles++;
    if (up_cycles == 1) begin m_wl = 1; m_rl = 1; end
    if (!running) return;
    if (wf && rs) begin
      old_wr = m_wr;
      if (m_latest_valid != 0) m_drop++;
      m_latest_valid = 0;
      m_rd = old_wr; m_wr = free_bank(old_wr, old_wr); m_disp = 1; m_wl = 1; m_rl = 1;
    end else if (wf) begin
      if (m_latest_valid != 0) m_drop++;
      m_latest = m_wr; m_latest_valid = 1;
      m_wr = free_bank(m_rd, m_latest); m_wl = 1;
    end else if (rs) begin
      if (m_latest_valid != 0) begin
        m_rd = m_latest; m_latest_valid = 0; m_disp = 1;
      end else begin
        m_rep++;
      end
      m_rl = 1;
    end
  endtask

  task automatic check_value(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, settle past the edge.
  task automatic applyStimulus(bit init, bit wf, bit rs);
    init_done = init;
    wr_done   = wf;
    rd_start  = rs;
    @(posedge clk);
    modelStep(init, wf, rs);
    #1;
  endtask

  task automatic checkOutput(string tag, int e_wr, int e_rd, int e_wl, int e_rl, int e_dv,
                             int e_drop, int e_rep);
    check_value({tag, ".wr_bank"},    int'(big_if.wr_bank),    e_wr);
    check_value({tag, ".rd_bank"},    int'(big_if.rd_bank),    e_rd);
    check_value({tag, ".wr_load"},    int'(big_if.wr_load),    e_wl);
    check_value({tag, ".rd_load"},    int'(big_if.rd_load),    e_rl);
    check_value({tag, ".disp_valid"}, int'(big_if.disp_valid), e_dv);
    check_value({tag, ".drop_cnt"},   int'(big_if.drop_cnt),   sat(e_drop, BIG_MAX));
    check_value({tag, ".repeat_cnt"}, int'(big_if.repeat_cnt), sat(e_rep, BIG_MAX));
    check_value({tag, ".small_drop"}, int'(small_if.drop_cnt), sat(e_drop, SMALL_MAX));
    check_value({tag, ".small_rep"},  int'(small_if.repeat_cnt), sat(e_rep, SMALL_MAX));
    check_value({tag, ".small_rd"},   int'(small_if.rd_bank),  e_rd);
    if (up_cycles >= 3)
      check_value({tag, ".banks_distinct"}, int'(big_if.wr_bank != big_if.rd_bank), 1);
  endtask

  task automatic checkModel(string tag);
    checkOutput(tag, m_wr, m_rd, m_wl, m_rl, m_disp, m_drop, m_rep);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_done = 1'b0; wr_done = 1'b0; rd_start = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 2, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit init; bit wf; bit rs;
    int wr; int rd; int wl; int rl; int dv; int drop; int rep;
  } vec_t;

  vec_t vecs[27];

  initial begin
    // init wf rs | wr rd wl rl dv drop rep
    vecs[0]  = '{1, 0, 0, 0, 2, 1, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 1, 2, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 2, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 1, 2, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1};
    vecs[8]  = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 1};
    vecs[9]  = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    vecs[10] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    vecs[11] = '{1, 1, 0, 2, 1, 1, 0, 1, 0, 1};
    vecs[12] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
    vecs[13] = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 1};
    vecs[14] = '{1, 0, 1, 0, 2, 0, 1, 1, 1, 1};
    vecs[15] = '{1, 1, 0, 1, 2, 1, 0, 1, 1, 1};
    vecs[16] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    vecs[17] = '{0, 0, 0, 0, 2, 0, 0, 0, 1, 1};
    vecs[18] = '{0, 1, 0, 0, 2, 0, 0, 0, 1, 1};
    vecs[19] = '{1, 0, 0, 0, 2, 1, 1, 0, 1, 1};
    vecs[20] = '{1, 0, 1, 0, 2, 0, 0, 0, 1, 1};
    vecs[21] = '{1, 0, 1, 0, 2, 0, 1, 0, 1, 2};
    vecs[22] = '{1, 0, 0, 0, 2, 0, 0, 0, 1, 2};
    vecs[23] = '{1, 1, 0, 1, 2, 1, 0, 0, 1, 2};
    vecs[24] = '{1, 1, 0, 0, 2, 1, 0, 0, 2, 2};
    vecs[25] = '{1, 0, 1, 0, 1, 0, 1, 1, 2, 2};
    vecs[26] = '{1, 0, 0, 0, 1, 0, 0, 1, 2, 2};

    do_reset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].init, vecs[i].wf, vecs[i].rs);
      checkOutput($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].wl, vecs[i].rl,
                  vecs[i].dv, vecs[i].drop, vecs[i].rep);
    end

    // Five starved reads: the 2-bit counter must pin at 3 while the wide one keeps going.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 1);
      check_value("starve.rd_load", int'(big_if.rd_load), 1);
      check_value("starve.rd_bank", int'(big_if.rd_bank), 1);
      applyStimulus(1, 0, 0);
      check_value("starve.rd_load_low", int'(big_if.rd_load), 0);
    end
    check_value("sat.big_rep", int'(big_if.repeat_cnt), 7);
    check_value("sat.small_rep", int'(small_if.repeat_cnt), 3);

    do_reset();

    begin
      bit r_init;
      r_init = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        if (r_init) r_init = ($urandom_range(99) >= 2);
        else        r_init = ($urandom_range(99) < 40);
        applyStimulus(r_init, $urandom_range(99) < 35, $urandom_range(99) < 35);
        checkModel("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
